// File: rtl/exec_unit_mc.sv
// Execution unit: single-cycle ALU/branch ops plus an iterative shift-add multiplier.
// All write-back and redirect outputs are registered one-cycle pulses.
module exec_unit_mc #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 3,
  parameter int NOWRITE_REG = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [DATA_W-1:0] in_arg0,
  input  logic [DATA_W-1:0] in_arg1,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic              in_flush,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_dest,
  output logic [DATA_W-1:0] wb_value,
  output logic              br_valid,
  output logic [DATA_W-1:0] br_target,
  output logic              busy
);
  localparam int SW = $clog2(DATA_W);
  localparam int CW = SW + 1;

  typedef enum logic {IDLE, MUL_RUN} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] acc, mcand, mplier;
  logic [ADDR_W-1:0] mdest;
  logic              accept;
  logic [SW-1:0]     sh;
  logic [DATA_W-1:0] sum, step_acc;

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state == MUL_RUN);
  assign accept   = in_valid && in_ready && !in_flush;
  assign sh       = in_arg1[SW-1:0];
  assign sum      = in_arg0 + in_arg1;
  assign step_acc = mplier[0] ? acc + mcand : acc;

  // An out-of-range NOWRITE_REG never matches, which disables suppression.
  function automatic logic is_nw(input logic [ADDR_W-1:0] d);
    return 32'(d) == 32'(NOWRITE_REG);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      mdest     <= '0;
      wb_valid  <= 1'b0;
      br_valid  <= 1'b0;
      wb_dest   <= '0;
      wb_value  <= '0;
      br_target <= '0;
    end else begin
      wb_valid <= 1'b0;
      br_valid <= 1'b0;
      if (in_flush) begin
        // Flush beats a multiply finishing on the same edge.
        state <= IDLE;
        cnt   <= '0;
      end else if (state == MUL_RUN) begin
        acc    <= step_acc;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (cnt == CW'(DATA_W - 1)) begin
          state    <= IDLE;
          cnt      <= '0;
          wb_valid <= !is_nw(mdest);
          wb_dest  <= mdest;
          wb_value <= step_acc;
        end
      end else if (accept) begin
        case (in_op)
          4'd0: begin
            wb_valid <= !is_nw(in_dest);
            wb_dest  <= in_dest;
            wb_value <= sum;
          end
          4'd1: begin
            wb_valid <= !is_nw(in_dest);
            wb_dest  <= in_dest;
            wb_value <= DATA_W'(in_arg0 < in_arg1);
          end
          4'd3: begin
            wb_valid <= !is_nw(in_dest);
            wb_dest  <= in_dest;
            wb_value <= in_arg0 << sh;
          end
          4'd7: begin
            wb_valid <= !is_nw(in_dest);
            wb_dest  <= in_dest;
            wb_value <= DATA_W'($signed(in_arg0) >>> sh);
          end
          4'd4: begin
            wb_valid  <= !is_nw(in_dest);
            wb_dest   <= in_dest;
            wb_value  <= in_pc;
            br_valid  <= 1'b1;
            br_target <= sum;
          end
          4'd5: begin
            br_valid  <= 1'b1;
            br_target <= sum;
          end
          4'd6: begin
            state  <= MUL_RUN;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= in_arg0;
            mplier <= in_arg1;
            mdest  <= in_dest;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_exec_unit_mc.sv
// Randomized scoreboard bench for exec_unit_mc (default parameters).
module tb_exec_unit_mc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_flush = 1'b0;
  logic [3:0]  in_op = 4'd2;
  logic [15:0] in_arg0 = '0, in_arg1 = '0, in_pc = '0;
  logic [2:0]  in_dest = '0;
  logic        in_ready, wb_valid, br_valid, busy;
  logic [2:0]  wb_dest;
  logic [15:0] wb_value, br_target;

  exec_unit_mc dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_arg0(in_arg0), .in_arg1(in_arg1), .in_pc(in_pc), .in_dest(in_dest),
    .in_flush(in_flush), .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_value(wb_value),
    .br_valid(br_valid), .br_target(br_target), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          e;
    bit          wv;
    logic [2:0]  wd;
    logic [15:0] wval;
    bit          bv;
    logic [15:0] bt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_bad = 0;
  int   edges = 0;
  int   busy_left = 0;
  bit   mul_pending = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (edge %0d)", nm, act, exp, edges);
    end
  endtask

  // Reference results from the arithmetic definition of each opcode.
  function automatic exp_t model(input logic [3:0] op, input int a, input int b, input int pc,
                                 input logic [2:0] d);
    exp_t r;
    int   s, sa;
    r = '{e: 0, wv: 0, wd: d, wval: 16'h0, bv: 0, bt: 16'h0};
    s = b % 16;
    case (op)
      4'd0: begin r.wv = 1; r.wval = 16'((a + b) % 65536); end
      4'd1: begin r.wv = 1; r.wval = (a < b) ? 16'd1 : 16'd0; end
      4'd3: begin r.wv = 1; r.wval = 16'((a * (1 << s)) % 65536); end
      4'd7: begin
        sa = (a >= 32768) ? a - 65536 : a;
        r.wv = 1;
        r.wval = 16'(sa >>> s);
      end
      4'd4: begin r.wv = 1; r.wval = 16'(pc); r.bv = 1; r.bt = 16'((a + b) % 65536); end
      4'd5: begin r.bv = 1; r.bt = 16'((a + b) % 65536); end
      4'd6: begin r.wv = 1; r.wval = 16'(longint'(a) * longint'(b) % 65536); end
      default: ;
    endcase
    if (d == 3'd7) r.wv = 0;
    return r;
  endfunction

  // One clock edge: advance the reference model with the inputs held across the edge.
  task automatic step();
    exp_t r;
    @(posedge clk);
    edges++;
    if (rst || in_flush) begin
      if (mul_pending) void'(sb.pop_back());
      mul_pending = 0;
      busy_left = 0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) mul_pending = 0;
    end else if (in_valid) begin
      r = model(in_op, int'(in_arg0), int'(in_arg1), int'(in_pc), in_dest);
      if (in_op == 4'd6) begin
        busy_left = 16;
        r.e = edges + 16;
        if (r.wv) begin sb.push_back(r); mul_pending = 1; end
      end else begin
        r.e = edges;
        if (r.wv || r.bv) sb.push_back(r);
      end
    end
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] pc, input logic [2:0] d);
    in_valid = 1; in_op = op; in_arg0 = a; in_arg1 = b; in_pc = pc; in_dest = d;
    step();
    in_valid = 0;
  endtask

  // Monitor: compares every cycle against the scoreboard head.
  initial begin
    int k;
    exp_t r;
    k = 0;
    forever begin
      @(negedge clk);
      k++;
      chk("in_ready", 32'(in_ready), 32'(busy_left == 0 && !rst));
      chk("busy", 32'(busy), 32'(busy_left > 0));
      while (sb.size() > 0 && sb[0].e < k) begin
        chk("missing_out_edge", 32'(sb[0].e), 32'(k));
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].e == k) begin
        r = sb.pop_front();
        chk("wb_valid", 32'(wb_valid), 32'(r.wv));
        chk("br_valid", 32'(br_valid), 32'(r.bv));
        if (r.wv) begin
          chk("wb_dest", 32'(wb_dest), 32'(r.wd));
          chk("wb_value", 32'(wb_value), 32'(r.wval));
        end
        if (r.bv) chk("br_target", 32'(br_target), 32'(r.bt));
      end else begin
        chk("spurious_out", 32'({wb_valid, br_valid}), 32'(0));
      end
    end
  end

  initial begin
    // Reset
    step(); step();
    #3;
    chk("rst_wb_dest", 32'(wb_dest), 0);
    chk("rst_wb_value", 32'(wb_value), 0);
    chk("rst_br_target", 32'(br_target), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    rst = 0;

    // Directed vectors, back to back
    issue(4'd0, 16'h7FFF, 16'h0003, 16'h0, 3'd2);
    issue(4'd0, 16'h7FFF, 16'h0003, 16'h0, 3'd7);
    issue(4'd4, 16'h0040, 16'hFFFE, 16'h0040, 3'd6);
    issue(4'd7, 16'h8010, 16'h0014, 16'h0, 3'd3);
    issue(4'd3, 16'h8010, 16'h0014, 16'h0, 3'd4);
    issue(4'd1, 16'hFFFF, 16'h0001, 16'h0, 3'd5);
    issue(4'd5, 16'h1000, 16'h0234, 16'h0, 3'd1);
    issue(4'd2, 16'h1111, 16'h2222, 16'h0, 3'd1);
    issue(4'd9, 16'h1111, 16'h2222, 16'h0, 3'd1);

    // Multiply with an ADD offered throughout the run
    issue(4'd6, 16'h0123, 16'h0011, 16'h0, 3'd1);
    in_valid = 1; in_op = 4'd0; in_arg0 = 16'h5555; in_arg1 = 16'h0001; in_dest = 3'd2;
    repeat (16) step();
    in_valid = 0;
    step();

    // Multiply flushed at N+5
    issue(4'd6, 16'h00FF, 16'h00FF, 16'h0, 3'd3);
    repeat (4) step();
    in_flush = 1; step(); in_flush = 0;
    step(); step();

    // Reset mid-multiply at N+3, then ADD on first edge after reset drops
    issue(4'd6, 16'h0AAA, 16'h0003, 16'h0, 3'd4);
    step(); step();
    rst = 1; step();
    #3;
    chk("midrst_wb_dest", 32'(wb_dest), 0);
    chk("midrst_wb_value", 32'(wb_value), 0);
    chk("midrst_br_target", 32'(br_target), 0);
    rst = 0;
    issue(4'd0, 16'h0010, 16'h0020, 16'h0, 3'd2);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h8000;
      if ($urandom_range(0, 7) == 0) b = 16'($urandom_range(0, 31));
      in_valid = ($urandom_range(0, 9) < 8);
      in_op    = ($urandom_range(0, 3) == 0) ? 4'd6 : 4'($urandom_range(0, 15));
      in_arg0  = a;
      in_arg1  = b;
      in_pc    = 16'($urandom);
      in_dest  = 3'($urandom_range(0, 7));
      in_flush = ($urandom_range(0, 49) == 0);
      rst      = ($urandom_range(0, 149) == 0);
      step();
    end
    in_valid = 0; in_flush = 0; rst = 0;
    repeat (20) step();
    #3;
    chk("queue_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
